pe_1d_core: RTL and testbench
=============================

PE_1D_CORE -- requirements
Module: pe_1d_core

Interface
REQ-001 Parameter global_index, default 0: index of this spin; excluded from its own coupling sums; selects its noise bit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ena  input  1  advance enable; low freezes all counters and outputs.
REQ-005 sample_time  input  32 (int)  cycles per update step; 0 treated as 1.
REQ-006 grad_count  input  32 (int)  number of initial update steps with noise enabled.
REQ-007 self_phase  input  phase_t  current phase of this spin.
REQ-008 coupling_phase  input  phase_t_mem  phases of all NUM_SPINS spins.
REQ-009 coupling_factor  input  NUM_SPINS x 32 signed  coupling weights J[j].
REQ-010 random_signal  input  NUM_SPINS  noise bits; only bit global_index is used.
REQ-011 self_phase_update  output  phase_t  registered new phase.
REQ-012 out_phase  output  phase_t  registered copy of self_phase at the last update step.
REQ-013 Hamiltonian  output  NL_out_phase_t  registered local energy.

Function
REQ-014 d[j] = (self_phase - coupling_phase[j]) mod 2^W, interpreted as W-bit two's complement ds[j].
REQ-015 s[j] = +1 if ds>0, 0 if ds==0, -1 if ds<0 (ds = -2^(W-1) gives -1).
REQ-016 c[j] = +1 if |ds| < 2^(W-2), 0 if equal, -1 if greater.
REQ-017 G = sum over j != global_index of J[j]*s[j]; Hint = -(sum over j != global_index of J[j]*c[j]); combinational, full-width signed, no overflow.
REQ-018 Step counter cnt counts 0..max(sample_time,1)-1 while ena; strobe when cnt reaches its max, then wraps to 0.
REQ-019 Step index k (saturating at grad_count) increments on each strobe; noise is enabled while k < grad_count.
REQ-020 Noise n = +1 if random_signal[global_index] else -1 when enabled; 0 otherwise.
REQ-021 On strobe: self_phase_update <= (self_phase - clamp(G, -(2^(W-2)-1), +(2^(W-2)-1)) + n) mod 2^W.
REQ-022 On strobe: out_phase <= self_phase; Hamiltonian <= Hint (saturated to NL_out_phase_t width).
REQ-023 Outputs change only on strobe edges; latency from strobe cycle to visible output is one clock.
REQ-024 sample_time changed mid-count: if cnt already >= new max, strobe on next cycle and wrap.
REQ-025 ena low and strobe coincident: no strobe, no update; ena has priority below reset.

Reset
REQ-026 Reset (sync, high) clears cnt, k, self_phase_update, out_phase and Hamiltonian to 0; reset overrides ena.
REQ-027 Reset asserted mid-step discards the partial count; first strobe after release occurs max(sample_time,1) enabled cycles later.

Structure
REQ-028 Shared package holds NUM_SPINS (default 8), W=PHASE_WIDTH (default 8), phase_t (W-bit unsigned), phase_t_reg, phase_t_mem (NUM_SPINS x phase_t), NL_out_phase_t (32-bit signed).
REQ-029 One sub-module, phase_coupler, computes s[j] and c[j] for one pair; NUM_SPINS instances are generated, followed by adder trees for G and Hint.

Verification
REQ-030 NUM_SPINS=4, global_index=0, J=[9,4,0,0], self=10, phase1=5, others=10, grad_count=0, sample_time=4 -> after 4 enabled cycles self_phase_update=6, out_phase=10, Hamiltonian=-4.
REQ-031 Same setup, grad_count=2, random_signal[0]=1 -> first two steps add +1 (7, 7 while inputs held); third step yields 6.
REQ-032 All phases equal, J alternating -8,0,8 -> G=0; self_phase_update = self_phase + n; Hamiltonian = -(sum of J[j], j != 0).
REQ-033 phase1 = self+128 (W=8), J1=4 -> s=-1, c=-1; self_phase_update = self+4, Hamiltonian=+4.
REQ-034 Large G (J1=1000) -> step clamped to 63; wrap-around check self=10 gives 10-63 mod 256 = 203.
REQ-035 ena low for 3 cycles mid-step delays strobe by 3 cycles; reset mid-step zeroes all outputs next edge.

Source files
------------

// File: rtl/pe_1d_core_pkg.sv
// -----------------------------------------------------------------------------
// pe_1d_core_pkg
//   Shared types, sizes and helpers for the 1-D spin processing element.
//   - NUM_SPINS / PHASE_WIDTH : array size and phase resolution
//   - phase_t, phase_t_reg    : W-bit unsigned phase (modular angle)
//   - phase_t_mem             : phases of all spins, packed
//   - NL_out_phase_t          : 32-bit signed energy output
//   - sum_t                   : adder-tree width, wide enough that the sum of
//                               NUM_SPINS full-range 32-bit weights cannot overflow
// -----------------------------------------------------------------------------
package pe_1d_core_pkg;

    localparam int NUM_SPINS   = 8;
    localparam int PHASE_WIDTH = 8;

    typedef logic [PHASE_WIDTH-1:0]  phase_t;
    typedef phase_t                  phase_t_reg;
    typedef phase_t [NUM_SPINS-1:0]  phase_t_mem;
    typedef logic signed [31:0]      NL_out_phase_t;

    // Ternary value {-1, 0, +1} for the sine/cosine sign terms.
    typedef logic signed [1:0]       tri_t;

    localparam int SUM_W       = 32 + $clog2(NUM_SPINS) + 1;
    localparam int TREE_LEAVES = 1 << $clog2(NUM_SPINS);
    typedef logic signed [SUM_W-1:0] sum_t;

    // Largest phase step a single update may take: a quarter turn minus one.
    localparam int   STEP_LIM  = (1 << (PHASE_WIDTH - 2)) - 1;
    localparam sum_t STEP_MAX  = sum_t'(STEP_LIM);
    localparam sum_t STEP_MIN  = -sum_t'(STEP_LIM);

    localparam sum_t NL_MAX    = $signed({{(SUM_W-32){1'b0}}, 32'h7FFF_FFFF});
    localparam sum_t NL_MIN    = $signed({{(SUM_W-32){1'b1}}, 32'h8000_0000});

    // Weight J by a ternary term; J is sign-extended first so -J never wraps.
    function automatic sum_t weigh(input logic [31:0] j_raw, input tri_t t);
        sum_t jx;
        jx = sum_t'($signed(j_raw));
        case (t)
            2'b01:   return jx;
            2'b11:   return -jx;
            default: return '0;
        endcase
    endfunction

    function automatic NL_out_phase_t sat_nl(input sum_t x);
        if (x > NL_MAX)      return 32'sh7FFF_FFFF;
        else if (x < NL_MIN) return 32'sh8000_0000;
        else                 return x[31:0];
    endfunction

endpackage

// File: rtl/pe_1d_core_phase_coupler.sv
// -----------------------------------------------------------------------------
// phase_coupler
//   Sign terms for one spin pair from their modular phase difference.
//   self_phase_i  : phase of this spin
//   other_phase_i : phase of the coupled spin
//   sign_o        : sign of the signed difference ds        (+1 / 0 / -1)
//   cos_o         : +1 inside a quarter turn, 0 on it, -1 beyond it
// -----------------------------------------------------------------------------
module phase_coupler
    import pe_1d_core_pkg::*;
(
    input  phase_t self_phase_i,
    input  phase_t other_phase_i,
    output tri_t   sign_o,
    output tri_t   cos_o
);

    localparam phase_t QUARTER = phase_t'(1 << (PHASE_WIDTH - 2));

    phase_t diff;
    phase_t mag;

    assign diff = self_phase_i - other_phase_i;

    // Two's-complement magnitude kept unsigned: the most negative difference
    // maps to exactly half a turn, which still fits in W bits.
    assign mag = diff[PHASE_WIDTH-1] ? (~diff + phase_t'(1)) : diff;

    assign sign_o = (diff == '0)         ? 2'sb00 :
                    diff[PHASE_WIDTH-1]  ? 2'sb11 : 2'sb01;

    assign cos_o  = (mag < QUARTER)      ? 2'sb01 :
                    (mag == QUARTER)     ? 2'sb00 : 2'sb11;

endmodule

// File: rtl/pe_1d_core.sv
// -----------------------------------------------------------------------------
// pe_1d_core
//   One spin of a phase-coupled Ising array. Every max(sample_time,1) enabled
//   cycles it takes a step against the clamped coupling gradient (plus noise
//   during the first grad_count steps) and registers its local energy.
//   clk, reset          : clock, synchronous active-high reset
//   ena                 : advance enable; low freezes everything
//   sample_time         : cycles per update step (0 behaves as 1)
//   grad_count          : number of initial steps with noise injected
//   self_phase          : current phase of this spin
//   coupling_phase      : phases of all spins
//   coupling_factor     : coupling weights J[j], signed 32-bit each
//   random_signal       : noise bits; only bit global_index is used
//   self_phase_update   : registered new phase
//   out_phase           : self_phase captured at the last update step
//   Hamiltonian         : registered local energy, saturated to 32 bits
// -----------------------------------------------------------------------------
module pe_1d_core
    import pe_1d_core_pkg::*;
#(
    parameter int global_index = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ena,
    input  logic [31:0]                 sample_time,
    input  logic [31:0]                 grad_count,
    input  phase_t                      self_phase,
    input  phase_t_mem                  coupling_phase,
    input  logic [NUM_SPINS-1:0][31:0]  coupling_factor,
    input  logic [NUM_SPINS-1:0]        random_signal,
    output phase_t                      self_phase_update,
    output phase_t                      out_phase,
    output NL_out_phase_t               Hamiltonian
);

    // ---------------------------------------------------------------- couplers
    tri_t s_w [NUM_SPINS];
    tri_t c_w [NUM_SPINS];

    for (genvar j = 0; j < NUM_SPINS; j++) begin : g_coupler
        phase_coupler u_coupler (
            .self_phase_i  (self_phase),
            .other_phase_i (coupling_phase[j]),
            .sign_o        (s_w[j]),
            .cos_o         (c_w[j])
        );
    end

    // ------------------------------------------------------------ adder trees
    // Heap-ordered binary trees: node n sums children 2n+1 and 2n+2, leaves
    // start at TREE_LEAVES-1. Unused leaves and this spin's own leaf are zero.
    sum_t g_tree [2*TREE_LEAVES-1];
    sum_t h_tree [2*TREE_LEAVES-1];

    // NOTE: every variable assigned in always_comb gets a value on every path
    // first, otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        for (int n = 0; n < 2*TREE_LEAVES-1; n++) begin
            g_tree[n] = '0;
            h_tree[n] = '0;
        end
        for (int i = 0; i < NUM_SPINS; i++) begin
            if (i != global_index) begin
                g_tree[TREE_LEAVES-1+i] = weigh(coupling_factor[i], s_w[i]);
                h_tree[TREE_LEAVES-1+i] = weigh(coupling_factor[i], c_w[i]);
            end
        end
        for (int n = TREE_LEAVES-2; n >= 0; n--) begin
            g_tree[n] = g_tree[2*n+1] + g_tree[2*n+2];
            h_tree[n] = h_tree[2*n+1] + h_tree[2*n+2];
        end
    end

    sum_t grad;
    sum_t h_int;
    assign grad  = g_tree[0];
    assign h_int = -h_tree[0];

    // ------------------------------------------------------- step timing
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] k_q,   k_d;
    logic [31:0] max_cnt;
    logic        strobe;
    logic        noise_en;

    assign max_cnt  = (sample_time == '0) ? '0 : sample_time - 32'd1;
    // ">=" rather than "==" so a shrinking sample_time strobes immediately.
    assign strobe   = ena && (cnt_q >= max_cnt);
    assign cnt_d    = strobe ? '0 : cnt_q + 32'd1;
    assign noise_en = (k_q < grad_count);
    assign k_d      = (strobe && noise_en) ? k_q + 32'd1 : k_q;

    // ------------------------------------------------------- phase update
    phase_t step_w;
    phase_t noise_w;
    phase_t upd_d;

    always_comb begin
        step_w = grad[PHASE_WIDTH-1:0];
        if (grad > STEP_MAX)      step_w = STEP_MAX[PHASE_WIDTH-1:0];
        else if (grad < STEP_MIN) step_w = STEP_MIN[PHASE_WIDTH-1:0];
    end

    assign noise_w = !noise_en                    ? '0          :
                     random_signal[global_index]  ? phase_t'(1) : '1;

    // Modular W-bit arithmetic; the wrap is the intended phase behaviour.
    assign upd_d = self_phase - step_w + noise_w;

    // ------------------------------------------------------- state
    phase_t_reg    self_phase_update_q;
    phase_t_reg    out_phase_q;
    NL_out_phase_t hamiltonian_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q               <= '0;
            k_q                 <= '0;
            self_phase_update_q <= '0;
            out_phase_q         <= '0;
            hamiltonian_q       <= '0;
        end else if (ena) begin
            cnt_q <= cnt_d;
            k_q   <= k_d;
            if (strobe) begin
                self_phase_update_q <= upd_d;
                out_phase_q         <= self_phase;
                hamiltonian_q       <= sat_nl(h_int);
            end
        end
    end

    assign self_phase_update = self_phase_update_q;
    assign out_phase         = out_phase_q;
    assign Hamiltonian       = hamiltonian_q;

endmodule

// File: tb/tb_pe_1d_core.sv
// -----------------------------------------------------------------------------
// tb_pe_1d_core
//   Directed and randomised checks of pe_1d_core against an arithmetic model
//   of the spin update rule.
// -----------------------------------------------------------------------------
module tb_pe_1d_core;
    import pe_1d_core_pkg::*;

    localparam int GI = 0;
    localparam int NS = NUM_SPINS;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ena;
    logic [31:0]            sample_time;
    logic [31:0]            grad_count;
    phase_t                 self_phase;
    phase_t_mem             coupling_phase;
    logic [NS-1:0][31:0]    coupling_factor;
    logic [NS-1:0]          random_signal;
    phase_t                 self_phase_update;
    phase_t                 out_phase;
    NL_out_phase_t          Hamiltonian;

    always #5 clk = ~clk;

    pe_1d_core #(.global_index(GI)) dut (
        .clk               (clk),
        .reset             (reset),
        .ena               (ena),
        .sample_time       (sample_time),
        .grad_count        (grad_count),
        .self_phase        (self_phase),
        .coupling_phase    (coupling_phase),
        .coupling_factor   (coupling_factor),
        .random_signal     (random_signal),
        .self_phase_update (self_phase_update),
        .out_phase         (out_phase),
        .Hamiltonian       (Hamiltonian)
    );

    int     n_vec = 0;
    int     n_err = 0;

    // Stimulus state, also the model's inputs.
    int     self_v;
    int     ph_a [NS];
    longint j_a  [NS];
    logic [NS-1:0] rnd;
    int     gc_m;
    int     k_m;
    int     prev_upd;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        self_phase = phase_t'(self_v);
        for (int j = 0; j < NS; j++) begin
            coupling_phase[j]  = phase_t'(ph_a[j]);
            coupling_factor[j] = j_a[j][31:0];
        end
        random_signal = rnd;
    endtask

    function automatic int wrap(input longint x);
        return int'(((x % 256) + 256) % 256);
    endfunction

    // Expected new phase and energy straight from the update rule.
    function automatic void model(input int noise, output int eu, output longint eh);
        longint g = 0;
        longint hs = 0;
        longint step;
        for (int j = 0; j < NS; j++) begin
            int ds, a, s, c;
            if (j == GI) continue;
            ds = wrap(self_v - ph_a[j]);
            if (ds >= 128) ds -= 256;
            s  = (ds > 0) ? 1 : (ds < 0) ? -1 : 0;
            a  = (ds < 0) ? -ds : ds;
            c  = (a < 64) ? 1 : (a == 64) ? 0 : -1;
            g  += j_a[j] * s;
            hs += j_a[j] * c;
        end
        step = (g > 63) ? 63 : (g < -63) ? -63 : g;
        eu   = wrap(self_v - step + noise);
        eh   = -hs;
        if (eh > 64'sd2147483647)  eh = 64'sd2147483647;
        if (eh < -64'sd2147483648) eh = -64'sd2147483648;
    endfunction

    function automatic int next_noise();
        int n;
        n = (k_m < gc_m) ? (rnd[GI] ? 1 : -1) : 0;
        if (k_m < gc_m) k_m++;
        return n;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        ena   = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        k_m      = 0;
        prev_upd = 0;
    endtask

    // One full update step: hold before the strobe edge, new values after it.
    task automatic do_step(input int st, input string tag);
        int     eff, eu;
        longint eh;
        sample_time = st;
        apply();
        model(next_noise(), eu, eh);
        eff = (st == 0) ? 1 : st;
        repeat (eff - 1) tick();
        check({tag, "_hold"}, self_phase_update, prev_upd);
        tick();
        check({tag, "_upd"}, self_phase_update, eu);
        check({tag, "_out"}, out_phase, self_v);
        check({tag, "_ham"}, Hamiltonian, eh);
        prev_upd = eu;
    endtask

    task automatic base_setup();
        self_v = 10;
        for (int j = 0; j < NS; j++) begin
            ph_a[j] = 10;
            j_a[j]  = 0;
        end
        ph_a[1] = 5;
        j_a[0]  = 9;
        j_a[1]  = 4;
        rnd     = '0;
    endtask

    initial begin
        int     eu;
        longint eh;

        reset = 1'b1; ena = 1'b1; sample_time = 4; grad_count = 0;
        self_phase = '0; coupling_phase = '0; coupling_factor = '0;
        random_signal = '0;
        gc_m = 0;
        base_setup();

        // Reset state
        do_reset();
        check("rst_upd", self_phase_update, 0);
        check("rst_out", out_phase, 0);
        check("rst_ham", Hamiltonian, 0);

        // Basic step without noise
        do_step(4, "basic");

        // Noise during the first two steps, then plain gradient
        grad_count = 2; gc_m = 2;
        rnd = '1;
        do_reset();
        do_step(4, "noise1");
        do_step(4, "noise2");
        do_step(4, "noise3");

        // Equal phases, alternating weights: zero gradient
        self_v = 50;
        for (int j = 0; j < NS; j++) begin
            ph_a[j] = 50;
            j_a[j]  = (j % 3 == 0) ? -8 : (j % 3 == 1) ? 0 : 8;
        end
        do_step(3, "equal");

        // Half-turn difference
        base_setup();
        ph_a[1] = 10 + 128;
        do_step(4, "half");

        // Gradient clamp with phase wrap
        base_setup();
        j_a[1] = 1000;
        do_step(4, "clamp");
        j_a[1] = -1000;
        do_step(2, "clamp_neg");

        // Energy saturation both ways
        for (int j = 0; j < NS; j++) begin
            ph_a[j] = 10;
            j_a[j]  = -64'sd2147483648;
        end
        do_step(1, "sat_pos");
        for (int j = 0; j < NS; j++) j_a[j] = 64'sd2147483647;
        do_step(0, "sat_neg");

        // ena low for three cycles in the middle of a step
        base_setup();
        sample_time = 4;
        apply();
        model(next_noise(), eu, eh);
        tick(); tick();
        ena = 1'b0;
        tick(); tick(); tick();
        ena = 1'b1;
        tick();
        check("ena_hold", self_phase_update, prev_upd);
        tick();
        check("ena_upd", self_phase_update, eu);
        check("ena_ham", Hamiltonian, eh);
        prev_upd = eu;

        // sample_time shrinks below the running count
        base_setup();
        j_a[1] = 20;
        sample_time = 6;
        apply();
        model(next_noise(), eu, eh);
        repeat (4) tick();
        check("shrink_hold", self_phase_update, prev_upd);
        sample_time = 2;
        tick();
        check("shrink_upd", self_phase_update, eu);
        prev_upd = eu;
        do_step(2, "shrink_next");

        // Reset in the middle of a step
        tick(); tick();
        reset = 1'b1;
        tick();
        check("midrst_upd", self_phase_update, 0);
        check("midrst_out", out_phase, 0);
        check("midrst_ham", Hamiltonian, 0);
        reset = 1'b0;
        k_m = 0; prev_upd = 0;
        do_step(4, "postrst");

        // Randomised steps with noise in the first three
        grad_count = 3; gc_m = 3;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            self_v = int'($urandom_range(0, 255));
            for (int j = 0; j < NS; j++) begin
                ph_a[j] = int'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0)
                    j_a[j] = longint'($signed($urandom()));
                else
                    j_a[j] = longint'($urandom_range(0, 600)) - 300;
            end
            rnd = NS'($urandom());
            do_step(int'($urandom_range(0, 5)), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
